alu16_sequencer: RTL and testbench



---
 rtl/alu16_seq_pkg.sv | 51 +++++
 rtl/alu_8.sv | 25 ++
 rtl/alu16_sequencer.sv | 144 ++++++++++++++
 tb/tb_alu16_sequencer.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/alu16_seq_pkg.sv
// Shared types and constants for the 16-bit register-pair sequencer
// and the 8-bit ALU it drives.
package alu16_seq_pkg;

    typedef enum logic [2:0] {
        OP_ADD16 = 3'd0,
        OP_SUB16 = 3'd1,
        OP_AND16 = 3'd2,
        OP_OR16  = 3'd3,
        OP_XOR16 = 3'd4,
        OP_INC16 = 3'd5,
        OP_DEC16 = 3'd6,
        OP_RSVD  = 3'd7
    } req_op_e;

    localparam logic [3:0] ALU_ADD = 4'd0;
    localparam logic [3:0] ALU_SUB = 4'd1;
    localparam logic [3:0] ALU_AND = 4'd2;
    localparam logic [3:0] ALU_OR  = 4'd3;
    localparam logic [3:0] ALU_XOR = 4'd4;
    localparam logic [3:0] ALU_INC = 4'd11;
    localparam logic [3:0] ALU_DEC = 4'd12;
    localparam logic [3:0] ALU_NOP = 4'hF;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LO,
        S_HI,
        S_FIX,
        S_DONE
    } state_e;

    localparam int FLAG_S = 2;
    localparam int FLAG_Z = 1;
    localparam int FLAG_C = 0;

    function automatic logic [3:0] alu_code(req_op_e op);
        logic [3:0] c;
        c = ALU_NOP;
        unique case (op)
            OP_ADD16: c = ALU_ADD;
            OP_SUB16: c = ALU_SUB;
            OP_AND16: c = ALU_AND;
            OP_OR16:  c = ALU_OR;
            OP_XOR16: c = ALU_XOR;
            default:  c = ALU_NOP;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/alu_8.sv
// Shared 8-bit ALU without carry-in; unknown opcodes return zero.
module alu_8
    import alu16_seq_pkg::*;
(
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic [3:0] opcode,
    output logic [7:0] y
);

    always_comb begin
        y = 8'h00;
        unique case (opcode)
            ALU_ADD: y = a + b;
            ALU_SUB: y = a - b;
            ALU_AND: y = a & b;
            ALU_OR:  y = a | b;
            ALU_XOR: y = a ^ b;
            ALU_INC: y = a + 8'd1;
            ALU_DEC: y = a - 8'd1;
            default: y = 8'h00;
        endcase
    end

endmodule

// File: rtl/alu16_sequencer.sv
// 16-bit Z80 pair arithmetic built from two or three passes of an
// external 8-bit ALU, with carry/borrow tracked locally.
module alu16_sequencer
    import alu16_seq_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [2:0]  req_op,
    input  logic [15:0] req_a,
    input  logic [15:0] req_b,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [15:0] resp_result,
    output logic [2:0]  resp_flags,
    output logic [7:0]  alu_a,
    output logic [7:0]  alu_b,
    output logic [3:0]  alu_opcode,
    input  logic [7:0]  alu_out
);

    state_e      state_q, state_d;
    req_op_e     op_q, op_d;
    logic [15:0] a_q, a_d;
    logic [15:0] b_q, b_d;
    logic [7:0]  lo_q, lo_d;
    logic [7:0]  hi_q, hi_d;
    logic        cy_lo_q, cy_lo_d;
    logic        cy_hi_q, cy_hi_d;
    logic        is_add, is_sub;
    logic [15:0] res;

    assign is_add = (op_q == OP_ADD16);
    assign is_sub = (op_q == OP_SUB16);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            op_q    <= OP_ADD16;
            a_q     <= 16'h0000;
            b_q     <= 16'h0000;
            lo_q    <= 8'h00;
            hi_q    <= 8'h00;
            cy_lo_q <= 1'b0;
            cy_hi_q <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            lo_q    <= lo_d;
            hi_q    <= hi_d;
            cy_lo_q <= cy_lo_d;
            cy_hi_q <= cy_hi_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        a_d        = a_q;
        b_d        = b_q;
        lo_d       = lo_q;
        hi_d       = hi_q;
        cy_lo_d    = cy_lo_q;
        cy_hi_d    = cy_hi_q;
        alu_a      = 8'h00;
        alu_b      = 8'h00;
        alu_opcode = ALU_ADD;
        unique case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    a_d     = req_a;
                    lo_d    = 8'h00;
                    hi_d    = 8'h00;
                    cy_lo_d = 1'b0;
                    cy_hi_d = 1'b0;
                    state_d = S_LO;
                    // INC/DEC reuse the add/sub carry paths with B=1
                    unique case (req_op_e'(req_op))
                        OP_INC16: begin
                            op_d = OP_ADD16;
                            b_d  = 16'h0001;
                        end
                        OP_DEC16: begin
                            op_d = OP_SUB16;
                            b_d  = 16'h0001;
                        end
                        default: begin
                            op_d = req_op_e'(req_op);
                            b_d  = req_b;
                        end
                    endcase
                end
            end
            S_LO: begin
                alu_a      = a_q[7:0];
                alu_b      = b_q[7:0];
                alu_opcode = alu_code(op_q);
                lo_d       = alu_out;
                cy_lo_d    = is_add ? (alu_out < a_q[7:0]) :
                             is_sub ? (a_q[7:0] < b_q[7:0]) : 1'b0;
                state_d    = S_HI;
            end
            S_HI: begin
                alu_a      = a_q[15:8];
                alu_b      = b_q[15:8];
                alu_opcode = alu_code(op_q);
                hi_d       = alu_out;
                cy_hi_d    = is_add ? (alu_out < a_q[15:8]) :
                             is_sub ? (a_q[15:8] < b_q[15:8]) : 1'b0;
                state_d    = cy_lo_q ? S_FIX : S_DONE;
            end
            S_FIX: begin
                alu_a      = hi_q;
                alu_opcode = is_sub ? ALU_DEC : ALU_INC;
                hi_d       = alu_out;
                cy_hi_d    = cy_hi_q |
                             (is_sub ? (hi_q == 8'h00) : (alu_out == 8'h00));
                state_d    = S_DONE;
            end
            S_DONE: begin
                if (resp_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign req_ready   = (state_q == S_IDLE);
    assign resp_valid  = (state_q == S_DONE);
    assign res         = {hi_q, lo_q};
    assign resp_result = resp_valid ? res : 16'h0000;

    always_comb begin
        resp_flags = 3'b000;
        if (resp_valid) begin
            resp_flags[FLAG_S] = res[15];
            resp_flags[FLAG_Z] = (res == 16'h0000);
            resp_flags[FLAG_C] = cy_hi_q;
        end
    end

endmodule

// File: tb/tb_alu16_sequencer.sv
// Randomized and directed bench for alu16_sequencer against a plain
// 16-bit arithmetic model.
module tb_alu16_sequencer;
    import alu16_seq_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [2:0]  req_op;
    logic [15:0] req_a;
    logic [15:0] req_b;
    logic        resp_valid;
    logic        resp_ready;
    logic [15:0] resp_result;
    logic [2:0]  resp_flags;
    logic [7:0]  alu_a;
    logic [7:0]  alu_b;
    logic [3:0]  alu_opcode;
    logic [7:0]  alu_out;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    alu16_sequencer dut (
        .clk(clk),
        .rst(rst),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_op(req_op),
        .req_a(req_a),
        .req_b(req_b),
        .resp_valid(resp_valid),
        .resp_ready(resp_ready),
        .resp_result(resp_result),
        .resp_flags(resp_flags),
        .alu_a(alu_a),
        .alu_b(alu_b),
        .alu_opcode(alu_opcode),
        .alu_out(alu_out)
    );

    alu_8 u_alu (
        .a(alu_a),
        .b(alu_b),
        .opcode(alu_opcode),
        .y(alu_out)
    );

    // Reference: whole-word arithmetic, carry is the true 17-bit
    // carry/borrow; a fix pass happens when the low byte carries.
    function automatic void model(
        input  logic [2:0]  op,
        input  logic [15:0] a,
        input  logic [15:0] b,
        output logic [15:0] r,
        output logic [2:0]  f,
        output int          lat
    );
        logic [16:0] w;
        logic        c;
        logic        fix;
        w = 17'd0; c = 1'b0; fix = 1'b0; r = 16'h0;
        case (op)
            3'd0: begin
                w = {1'b0, a} + {1'b0, b}; r = w[15:0]; c = w[16];
                fix = (int'(a[7:0]) + int'(b[7:0])) > 255;
            end
            3'd1: begin
                r = a - b; c = (a < b); fix = (a[7:0] < b[7:0]);
            end
            3'd2: r = a & b;
            3'd3: r = a | b;
            3'd4: r = a ^ b;
            3'd5: begin
                r = a + 16'd1; c = (a == 16'hFFFF);
                fix = (a[7:0] == 8'hFF);
            end
            3'd6: begin
                r = a - 16'd1; c = (a == 16'h0000);
                fix = (a[7:0] == 8'h00);
            end
            default: r = 16'h0;
        endcase
        f = {r[15], r == 16'h0, c};
        lat = fix ? 3 : 2;
    endfunction

    task automatic issue(input logic [2:0] op, input logic [15:0] a,
                         input logic [15:0] b, output int lat);
        req_valid = 1'b1; req_op = op; req_a = a; req_b = b;
        @(posedge clk); #1;
        req_valid = 1'b0;
        lat = 0;
        for (int i = 1; i <= 10; i++) begin
            @(posedge clk); #1;
            if (resp_valid) begin
                lat = i;
                break;
            end
        end
    endtask

    task automatic finish_resp();
        resp_ready = 1'b1;
        @(posedge clk); #1;
        resp_ready = 1'b0;
    endtask

    task automatic run_check(input string nm, input logic [2:0] op,
                             input logic [15:0] a, input logic [15:0] b);
        logic [15:0] er;
        logic [2:0]  ef;
        int          el, lat;
        model(op, a, b, er, ef, el);
        issue(op, a, b, lat);
        checks++;
        if (lat !== el || resp_result !== er || resp_flags !== ef) begin
            errors++;
            $display("FAIL %s op=%0d a=%h b=%h got r=%h f=%b lat=%0d exp r=%h f=%b lat=%0d",
                     nm, op, a, b, resp_result, resp_flags, lat, er, ef, el);
        end
        if (lat != 0) finish_resp();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        checks++;
        if (req_ready !== 1'b1 || resp_valid !== 1'b0 ||
            resp_result !== 16'h0 || resp_flags !== 3'b0 ||
            alu_a !== 8'h0 || alu_b !== 8'h0 || alu_opcode !== ALU_ADD) begin
            errors++;
            $display("FAIL reset rdy=%b vld=%b r=%h f=%b alu=%h/%h/%h exp 1/0/0/0/0/0/0",
                     req_ready, resp_valid, resp_result, resp_flags,
                     alu_a, alu_b, alu_opcode);
        end
    endtask

    task automatic test_directed();
        run_check("add_fix",   3'd0, 16'h12FF, 16'h0001);
        run_check("add_wrap",  3'd0, 16'hFFFF, 16'h0001);
        run_check("inc_ff",    3'd5, 16'h00FF, 16'h1234);
        run_check("inc_wrap",  3'd5, 16'hFFFF, 16'h0000);
        run_check("sub_brw",   3'd1, 16'h1000, 16'h0001);
        run_check("sub_wrap",  3'd1, 16'h0000, 16'h0001);
        run_check("dec_one",   3'd6, 16'h0001, 16'hBEEF);
        run_check("dec_wrap",  3'd6, 16'h0000, 16'h0000);
        run_check("xor",       3'd4, 16'hA5A5, 16'hFFFF);
        run_check("and",       3'd2, 16'hF0F0, 16'h3C3C);
        run_check("or",        3'd3, 16'h0F00, 16'h00F0);
        run_check("rsvd",      3'd7, 16'h1234, 16'h5678);
    endtask

    task automatic test_random();
        logic [15:0] a, b;
        logic [2:0]  op;
        for (int n = 0; n < 200; n++) begin
            op = 3'($urandom_range(0, 7));
            a = 16'($urandom);
            b = 16'($urandom);
            if ($urandom_range(0, 3) == 0) a[7:0] = 8'hFF;
            if ($urandom_range(0, 3) == 0) b[7:0] = 8'h00;
            run_check("random", op, a, b);
        end
    endtask

    task automatic test_backpressure();
        logic [15:0] r0;
        logic [2:0]  f0;
        int          lat;
        issue(3'd0, 16'h80FF, 16'h0001, lat);
        r0 = resp_result; f0 = resp_flags;
        checks++;
        if (lat !== 3 || r0 !== 16'h8100 || f0 !== 3'b100) begin
            errors++;
            $display("FAIL bp_first r=%h f=%b lat=%0d exp 8100 100 3",
                     r0, f0, lat);
        end
        req_valid = 1'b1; req_op = 3'd1; req_a = 16'h5555; req_b = 16'h1111;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            checks++;
            if (resp_valid !== 1'b1 || req_ready !== 1'b0 ||
                resp_result !== 16'h8100 || resp_flags !== 3'b100) begin
                errors++;
                $display("FAIL bp_hold cyc=%0d vld=%b rdy=%b r=%h f=%b exp 1 0 8100 100",
                         i, resp_valid, req_ready, resp_result, resp_flags);
            end
        end
        req_valid = 1'b0;
        finish_resp();
        checks++;
        if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin
            errors++;
            $display("FAIL bp_release rdy=%b vld=%b exp 1 0",
                     req_ready, resp_valid);
        end
        run_check("bp_next", 3'd1, 16'h5555, 16'h1111);
    endtask

    task automatic test_reset_mid();
        req_valid = 1'b1; req_op = 3'd0; req_a = 16'h00FF; req_b = 16'h00FF;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        checks++;
        if (req_ready !== 1'b1 || resp_valid !== 1'b0 ||
            resp_result !== 16'h0 || resp_flags !== 3'b0 ||
            alu_a !== 8'h0 || alu_b !== 8'h0 || alu_opcode !== ALU_ADD) begin
            errors++;
            $display("FAIL rst_mid rdy=%b vld=%b r=%h f=%b alu=%h/%h/%h exp 1/0/0/0/0/0/0",
                     req_ready, resp_valid, resp_result, resp_flags,
                     alu_a, alu_b, alu_opcode);
        end
        run_check("after_rst", 3'd0, 16'h0001, 16'h0002);
    endtask

    initial begin
        rst = 1'b0; req_valid = 1'b0; req_op = 3'd0;
        req_a = 16'h0; req_b = 16'h0; resp_ready = 1'b0;
        test_reset();
        test_directed();
        test_backpressure();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
